izz_mem: RTL and testbench

IZZ_MEM -- requirements
Module: izz_mem

---
 rtl/izz_mem_if.sv | 28 ++
 rtl/izz_mem.sv | 124 ++++++++++++
 tb/tb_izz_mem.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/izz_mem_if.sv
// ============================================================================
// Module      : izz_mem_if
// Description : Stream bundle for izz_mem (enable, zigzag input, raster output).
//               Optional out_sob present when IZZ_SOB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface izz_mem_if #(
  parameter int DW = 8
);
  logic          en;
  logic          in_valid;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic [DW-1:0] data_out;
`ifdef IZZ_SOB_EN
  logic          out_sob;

  modport master (output en, in_valid, data_in, input out_valid, data_out, out_sob);
  modport slave  (input en, in_valid, data_in, output out_valid, data_out, out_sob);
`else
  modport master (output en, in_valid, data_in, input out_valid, data_out);
  modport slave  (input en, in_valid, data_in, output out_valid, data_out);
`endif
endinterface

`default_nettype wire

// File: rtl/izz_mem.sv
// ============================================================================
// Module      : izz_mem
// Description : Inverse zigzag reorder of 8x8 coefficient blocks using
//               ping-pong 64-entry banks. Define IZZ_SOB_EN for out_sob.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module izz_mem #(
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst,
  izz_mem_if.slave   bus
);

  // Raster address of each zigzag index (JPEG scan order).
  localparam int ZZ_TO_RASTER [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  rd_state_e     rd_state_q, rd_state_d;
  logic [5:0]    wr_cnt_q, wr_cnt_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;
  logic          bank_q, bank_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] data_out_q, data_out_d;
`ifdef IZZ_SOB_EN
  logic          sob_q, sob_d;
`endif

  logic [DW-1:0] mem_q [128];
  logic          accept;
  logic          blk_done;
  logic [5:0]    wr_raster;

  assign accept    = bus.en && bus.in_valid;
  assign blk_done  = accept && (wr_cnt_q == 6'd63);
  assign wr_raster = 6'(ZZ_TO_RASTER[wr_cnt_q]);

  // Bank bank_q is being filled; the other bank is the one being drained.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[{bank_q, wr_raster}] <= bus.data_in;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    bank_d      = bank_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
`ifdef IZZ_SOB_EN
    sob_d       = sob_q;
`endif
    if (bus.en) begin
      if (accept) begin
        wr_cnt_d = wr_cnt_q + 6'd1;
      end
      if (rd_state_q == RD_RUN) begin
        out_valid_d = 1'b1;
        data_out_d  = mem_q[{~bank_q, rd_cnt_q}];
        rd_cnt_d    = rd_cnt_q + 6'd1;
        if (rd_cnt_q == 6'd63) begin
          rd_state_d = RD_IDLE;
        end
      end else begin
        out_valid_d = 1'b0;
      end
`ifdef IZZ_SOB_EN
      sob_d = (rd_state_q == RD_RUN) && (rd_cnt_q == 6'd0);
`endif
      // A completed block overrides the end of the previous read phase.
      if (blk_done) begin
        bank_d     = ~bank_q;
        rd_state_d = RD_RUN;
        rd_cnt_d   = 6'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      wr_cnt_q    <= 6'd0;
      rd_cnt_q    <= 6'd0;
      bank_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
`ifdef IZZ_SOB_EN
      sob_q       <= 1'b0;
`endif
    end else begin
      rd_state_q  <= rd_state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      bank_q      <= bank_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
`ifdef IZZ_SOB_EN
      sob_q       <= sob_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
`ifdef IZZ_SOB_EN
  assign bus.out_sob   = sob_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_izz_mem.sv
// ============================================================================
// Module      : tb_izz_mem
// Description : Directed self-checking bench for izz_mem (gaps, back-to-back,
//               enable freeze, mid-block reset). Honours IZZ_SOB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_izz_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  izz_mem_if #(.DW(8)) bus ();

  izz_mem #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Zigzag index found at each raster position, row by row.
  int inv_tab [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q_out [$];
  int         runs  [$];
  int         sob_idx [$];
  int         run_len = 0;
  logic       en_at_edge = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Record every sample produced on an enabled edge, plus out_valid run lengths.
  always @(posedge clk) en_at_edge <= bus.en;
  always @(negedge clk) begin
    if (en_at_edge && !rst) begin
      if (bus.out_valid) begin
        q_out.push_back(bus.data_out);
        run_len++;
`ifdef IZZ_SOB_EN
        if (bus.out_sob) sob_idx.push_back(q_out.size() - 1);
`endif
      end else if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed(input int base, input bit gaps);
    for (int k = 0; k < 64; k++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = 8'(base + k);
      tick();
      if (gaps && (k % 8 == 7) && k != 63) begin
        bus.in_valid = 1'b0;
        idle(3);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_log();
    q_out.delete();
    runs.delete();
    sob_idx.delete();
  endtask

  task automatic chk_block(input string tag, input int off, input int base);
    for (int r = 0; r < 64; r++) begin
      if (off + r < q_out.size())
        chk($sformatf("%s_r%0d", tag, r), 32'(q_out[off + r]), 32'(inv_tab[r] + base));
      else
        chk($sformatf("%s_r%0d_missing", tag, r), 32'(q_out.size()), 32'(off + r + 1));
    end
  endtask

  task automatic chk_runs(input string tag, input int len);
    chk({tag, "_nruns"}, 32'(runs.size()), 32'd1);
    chk({tag, "_runlen"}, 32'(runs.size() > 0 ? runs[0] : 0), 32'(len));
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    rst          = 1'b1;
    idle(2);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
`ifdef IZZ_SOB_EN
    chk("rst_sob", 32'(bus.out_sob), 32'd0);
`endif
    rst    = 1'b0;
    bus.en = 1'b1;

    // Single block, value = zigzag index; exact one-edge latency.
    clear_log();
    feed(0, 1'b0);
    chk("t1_lat_pre", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_lat_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_lat_data", 32'(bus.data_out), 32'd0);
    idle(70);
    chk("t1_count", 32'(q_out.size()), 32'd64);
    if (q_out.size() == 64) begin
      chk("t1_r1",  32'(q_out[1]),  32'd1);
      chk("t1_r2",  32'(q_out[2]),  32'd5);
      chk("t1_r3",  32'(q_out[3]),  32'd6);
      chk("t1_r8",  32'(q_out[8]),  32'd2);
      chk("t1_r16", 32'(q_out[16]), 32'd3);
      chk("t1_r32", 32'(q_out[32]), 32'd10);
      chk("t1_r63", 32'(q_out[63]), 32'd63);
    end
    chk_block("t1", 0, 0);
    chk_runs("t1", 64);
    chk("t1_hold_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_hold_data", 32'(bus.data_out), 32'd63);

    // Four back-to-back blocks must stream out with no gap.
    clear_log();
    for (int b = 0; b < 4; b++) feed(64 * b, 1'b0);
    idle(70);
    chk("t2_count", 32'(q_out.size()), 32'd256);
    for (int b = 0; b < 4; b++) chk_block($sformatf("t2_b%0d", b), 64 * b, 64 * b);
    chk_runs("t2", 256);
`ifdef IZZ_SOB_EN
    chk("t2_nsob", 32'(sob_idx.size()), 32'd4);
    for (int b = 0; b < 4; b++)
      chk($sformatf("t2_sob%0d", b), 32'(sob_idx.size() > b ? sob_idx[b] : -1), 32'(64 * b));
`endif

    // Input gaps every 8 samples.
    clear_log();
    feed(0, 1'b1);
    idle(70);
    chk("t3_count", 32'(q_out.size()), 32'd64);
    chk_block("t3", 0, 0);
    chk_runs("t3", 64);

    // Enable dropped for 5 cycles mid read; in_valid asserted meanwhile must be ignored.
    clear_log();
    feed(0, 1'b0);
    idle(20);
    chk("t4_pre_data", 32'(bus.data_out), 32'd17);
    bus.en       = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_frz_valid%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t4_frz_data%0d", i), 32'(bus.data_out), 32'd17);
    end
    bus.in_valid = 1'b0;
    bus.en       = 1'b1;
    idle(60);
    chk("t4_count", 32'(q_out.size()), 32'd64);
    chk_block("t4", 0, 0);
    chk_runs("t4", 64);

    // Reset after 40 samples discards the partial block.
    clear_log();
    for (int k = 0; k < 40; k++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = 8'(k);
      tick();
    end
    rst         = 1'b1;
    bus.data_in = 8'd200;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_data", 32'(bus.data_out), 32'd0);
    feed(100, 1'b0);
    chk("t5_pre_valid", 32'(q_out.size()), 32'd0);
    idle(70);
    chk("t5_count", 32'(q_out.size()), 32'd64);
    chk_block("t5", 0, 100);
    chk_runs("t5", 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
